seq_detect_arb: RTL and testbench
=================================

// Module: seq_detect_arb
// PURPOSE
//  Shares one programmable serial pattern detector between two packet requesters.
//  Round-robin arbitration at packet boundaries. Granted words are serialized
//  MSB-first into the detector, one bit per clock.
//  Reports each match (source, bit position) and keeps saturating per-requester match counts.
//  Sits between the word-level producers and the bit-serial detection path.
// PARAMETERS
//  DW        8   bits per data word
//  PLEN_MAX  8   maximum pattern length / detector history depth
//  CW        8   width of per-requester match counters
// PORTS
//  clk          in   1         clock; all state updates on the rising edge
//  rst_n        in   1         asynchronous active-low reset
//  cfg_pattern  in   PLEN_MAX  pattern; bit [cfg_len-1] is the first-received bit
//  cfg_len      in   4         pattern length, 1..PLEN_MAX
//  cfg_overlap  in   1         1 = overlapping matches allowed
//  clr_cnt      in   1         synchronous clear of cnt0/cnt1
//  reqN_valid   in   1         N=0,1: word available
//  reqN_data    in   DW        N=0,1: word
//  reqN_last    in   1         N=0,1: word is the last of its packet
//  reqN_ready   out  1         N=0,1: word accepted when valid&ready
//  match_valid  out  1         one-cycle pulse per match
//  match_src    out  1         requester that owned the matching bit
//  match_pos    out  16        0-based bit index in packet of final matching bit (saturates)
//  cnt0, cnt1   out  CW        saturating match counts per requester
//  busy         out  1         FSM not in IDLE
// BEHAVIOUR
//  Reset:
//   - All outputs 0; FSM to IDLE; history cleared.
//   - RR pointer set so req0 wins the first tie.
//  FSM, one-hot: IDLE, LOAD, SHIFT, FLUSH.
//  IDLE:
//   - If any reqN_valid, register grant and go to LOAD.
//   - On a tie, grant the requester not served last; otherwise grant the only valid one.
//   - Latch cfg_pattern/cfg_len/cfg_overlap here; config is held for the whole packet.
//  LOAD:
//   - reqG_ready = 1 for the granted requester only; the other ready is always 0.
//   - On valid&ready, capture data/last and go to SHIFT.
//   - If valid is low, stay in LOAD and keep the grant; no timeout.
//  SHIFT:
//   - Feed one bit per cycle, MSB first, for DW cycles.
//   - After the LSB: if last, go to FLUSH; else go to LOAD.
//   - Throughput is DW+1 cycles per word.
//  FLUSH (1 cycle):
//   - Clear detector history and the packet bit counter.
//   - Update the RR pointer to the granted requester; go to IDLE.
//   - No match ever spans two packets.
//  Detector:
//   - history <= {history, bit}; bits_seen counts bits since packet start or since the last match.
//   - Match when the low L bits of history equal the low L bits of the pattern, and bits_seen >= L.
//   - L is the latched cfg_len; 0 -> no matches; values > PLEN_MAX clamp to PLEN_MAX.
//   - On a match with cfg_overlap=0, bits_seen resets to 0.
//   - Match outputs are registered: match_valid pulses 1 cycle after the matching bit is shifted.
//  Counters:
//   - cntG += 1 on each match, saturating at 2^CW-1.
//   - clr_cnt wins over a same-cycle increment.
//   - match_valid still pulses while a counter is saturated.
//  Async reset mid-packet:
//   - The packet is abandoned with no further ready/match.
//   - The requester must resend it.
// STRUCTURE
//  - Package seq_detect_pkg: one-hot state localparams (ST_IDLE..ST_FLUSH), DW/PLEN_MAX defaults.
//  - Sub-module pattern_match_core: history shift register, bits_seen counter, compare,
//    and overlap handling.
//  - Inputs of pattern_match_core: bit_in, bit_en, clr, latched config. Output: hit.
//  - Top level holds FSM, RR pointer, serializer, position counter, counters and output registers.
// TESTING
//  1. pat=0000_1101, len=4, ovl=1; req0 sends one word 8'b1101_1010, last=1
//     -> match_pos 3 and 6, src=0; cnt0=2.
//  2. Same as 1 with ovl=0 -> single match at pos 3; cnt0=1.
//  3. Two-word packet 8'h03 then 8'h40, len=4, pat=1101
//     -> one match, match_pos=9, across the word boundary.
//  4. req0 packet ends ...110, req1 packet starts 1... -> no match.
//     Both valid out of reset -> grant order req0, req1, req0.
//  5. rst_n low mid-SHIFT -> ready/match_valid/busy/cnt drop to 0 immediately;
//     after release, req0 wins a tie.
//  6. 260 matching packets on req1 -> cnt1=255 held; clr_cnt with a same-cycle match -> cnt1=0.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared widths, defaults and one-hot FSM encoding for the shared
// serial pattern detector and its two-requester front end.
package seq_detect_pkg;
  localparam int unsigned DW_DEF       = 8;
  localparam int unsigned PLEN_MAX_DEF = 8;
  localparam int unsigned CW_DEF       = 8;
  localparam int unsigned LEN_W        = 4;
  localparam int unsigned POS_W        = 16;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_LOAD  = 4'b0010,
    ST_SHIFT = 4'b0100,
    ST_FLUSH = 4'b1000
  } state_t;
endpackage

// File: rtl/pattern_match_core.sv
// Bit-serial pattern matcher: history shift register, bits-seen counter,
// masked compare against the latched pattern, overlap handling.
module pattern_match_core
  import seq_detect_pkg::*;
#(
  parameter int unsigned PLEN_MAX = PLEN_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                bit_in,
  input  logic                bit_en,
  input  logic                clr,
  input  logic [PLEN_MAX-1:0] pattern,
  input  logic [LEN_W-1:0]    len,
  input  logic                overlap,
  output logic                hit
);
  logic [PLEN_MAX-1:0] r_hist;
  logic [LEN_W-1:0]    r_seen;
  logic [PLEN_MAX-1:0] w_hist_nxt;
  logic [PLEN_MAX-1:0] w_mask;
  logic [LEN_W-1:0]    w_len;
  logic [LEN_W-1:0]    w_seen_nxt;

  assign w_len      = (len > LEN_W'(PLEN_MAX)) ? LEN_W'(PLEN_MAX) : len;
  assign w_hist_nxt = {r_hist[PLEN_MAX-2:0], bit_in};
  assign w_seen_nxt = (r_seen >= LEN_W'(PLEN_MAX)) ? r_seen : r_seen + LEN_W'(1);

  // Select the low L history bits for comparison
  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < PLEN_MAX; i++) w_mask[i] = (i < 32'(w_len));
  end

  assign hit = bit_en && (w_len != '0) &&
               (((w_hist_nxt ^ pattern) & w_mask) == '0) &&
               (w_seen_nxt >= w_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
      r_seen <= '0;
    end else if (clr) begin
      r_hist <= '0;
      r_seen <= '0;
    end else if (bit_en) begin
      r_hist <= w_hist_nxt;
      r_seen <= (hit && !overlap) ? '0 : w_seen_nxt;
    end
  end
endmodule

// File: rtl/seq_detect_arb.sv
// Round-robin arbiter that serializes granted packet words MSB-first into a
// shared pattern matcher and reports matches with per-requester counts.
module seq_detect_arb
  import seq_detect_pkg::*;
#(
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned PLEN_MAX = PLEN_MAX_DEF,
  parameter int unsigned CW       = CW_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PLEN_MAX-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]    cfg_len,
  input  logic                cfg_overlap,
  input  logic                clr_cnt,
  input  logic                req0_valid,
  input  logic [DW-1:0]       req0_data,
  input  logic                req0_last,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [DW-1:0]       req1_data,
  input  logic                req1_last,
  output logic                req1_ready,
  output logic                match_valid,
  output logic                match_src,
  output logic [POS_W-1:0]    match_pos,
  output logic [CW-1:0]       cnt0,
  output logic [CW-1:0]       cnt1,
  output logic                busy
);
  localparam int unsigned BC_W = (DW > 1) ? $clog2(DW) : 1;

  state_t              r_state, w_state_nxt;
  logic                r_grant, w_grant_nxt;
  logic                r_rr_last;
  logic [PLEN_MAX-1:0] r_cfg_pattern;
  logic [LEN_W-1:0]    r_cfg_len;
  logic                r_cfg_overlap;
  logic [DW-1:0]       r_shreg;
  logic                r_last;
  logic [BC_W-1:0]     r_bit_cnt;
  logic [POS_W-1:0]    r_pos;
  logic                r_ready0, r_ready1, r_busy;
  logic                r_match_valid, r_match_src;
  logic [POS_W-1:0]    r_match_pos;
  logic [CW-1:0]       r_cnt0, r_cnt1;
  logic                w_accept, w_bit_en, w_word_end, w_hit, w_flush;

  assign w_accept   = (r_ready0 && req0_valid) || (r_ready1 && req1_valid);
  assign w_bit_en   = (r_state == ST_SHIFT);
  assign w_word_end = w_bit_en && (r_bit_cnt == BC_W'(DW - 1));
  assign w_flush    = (r_state == ST_FLUSH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  // Tie goes to the requester not served last
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    case (r_state)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          w_grant_nxt = (req0_valid && req1_valid) ? ~r_rr_last : req1_valid;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD:  if (w_accept) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_word_end) w_state_nxt = r_last ? ST_FLUSH : ST_LOAD;
      ST_FLUSH: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  pattern_match_core #(.PLEN_MAX(PLEN_MAX)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .bit_in  (r_shreg[DW-1]),
    .bit_en  (w_bit_en),
    .clr     (w_flush),
    .pattern (r_cfg_pattern),
    .len     (r_cfg_len),
    .overlap (r_cfg_overlap),
    .hit     (w_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_last     <= 1'b1;
      r_cfg_pattern <= '0;
      r_cfg_len     <= '0;
      r_cfg_overlap <= 1'b0;
      r_shreg       <= '0;
      r_last        <= 1'b0;
      r_bit_cnt     <= '0;
      r_pos         <= '0;
      r_ready0      <= 1'b0;
      r_ready1      <= 1'b0;
      r_busy        <= 1'b0;
      r_match_valid <= 1'b0;
      r_match_src   <= 1'b0;
      r_match_pos   <= '0;
      r_cnt0        <= '0;
      r_cnt1        <= '0;
    end else begin
      r_ready0      <= (w_state_nxt == ST_LOAD) && !w_grant_nxt;
      r_ready1      <= (w_state_nxt == ST_LOAD) && w_grant_nxt;
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_match_valid <= w_hit;
      if (r_state == ST_IDLE) begin
        r_cfg_pattern <= cfg_pattern;
        r_cfg_len     <= cfg_len;
        r_cfg_overlap <= cfg_overlap;
      end
      if (w_accept) begin
        r_shreg   <= r_grant ? req1_data : req0_data;
        r_last    <= r_grant ? req1_last : req0_last;
        r_bit_cnt <= '0;
      end else if (w_bit_en) begin
        r_shreg   <= {r_shreg[DW-2:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + BC_W'(1);
      end
      if (w_flush) begin
        r_pos     <= '0;
        r_rr_last <= r_grant;
      end else if (w_bit_en && (r_pos != '1)) begin
        r_pos <= r_pos + POS_W'(1);
      end
      if (w_hit) begin
        r_match_src <= r_grant;
        r_match_pos <= r_pos;
      end
      // Clear has priority over a same-cycle increment
      if (clr_cnt) begin
        r_cnt0 <= '0;
        r_cnt1 <= '0;
      end else if (w_hit) begin
        if (!r_grant && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + CW'(1);
        if (r_grant && (r_cnt1 != '1))  r_cnt1 <= r_cnt1 + CW'(1);
      end
    end
  end

  assign req0_ready  = r_ready0;
  assign req1_ready  = r_ready1;
  assign busy        = r_busy;
  assign match_valid = r_match_valid;
  assign match_src   = r_match_src;
  assign match_pos   = r_match_pos;
  assign cnt0        = r_cnt0;
  assign cnt1        = r_cnt1;
endmodule

// File: tb/tb_seq_detect_arb.sv
// Directed self-checking bench for seq_detect_arb: arbitration order,
// match positions, packet isolation, reset abandonment and counter saturation.
module tb_seq_detect_arb;
  logic        clk;
  logic        rst_n;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic        cfg_overlap;
  logic        clr_cnt;
  logic        req0_valid, req0_last, req0_ready;
  logic [7:0]  req0_data;
  logic        req1_valid, req1_last, req1_ready;
  logic [7:0]  req1_data;
  logic        match_valid, match_src;
  logic [15:0] match_pos;
  logic [7:0]  cnt0, cnt1;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  q0_d[$];
  logic        q0_l[$];
  logic [7:0]  q1_d[$];
  logic        q1_l[$];
  logic        m_src[$];
  logic [15:0] m_pos[$];
  logic        g_order[$];

  seq_detect_arb dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .clr_cnt(clr_cnt),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .match_valid(match_valid), .match_src(match_src), .match_pos(match_pos),
    .cnt0(cnt0), .cnt1(cnt1), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Record matches and handshakes away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (match_valid) begin
        m_src.push_back(match_src);
        m_pos.push_back(match_pos);
      end
      if (req0_valid && req0_ready) g_order.push_back(1'b0);
      if (req1_valid && req1_ready) g_order.push_back(1'b1);
      check("ready_exclusive", 32'(req0_ready & req1_ready), 0);
    end
  end

  function automatic logic [15:0] pos_at(input int i);
    if (i < m_pos.size()) return m_pos[i];
    return 16'hDEAD;
  endfunction

  function automatic logic [1:0] src_at(input int i);
    if (i < m_src.size()) return {1'b0, m_src[i]};
    return 2'b11;
  endfunction

  function automatic logic [1:0] grant_at(input int i);
    if (i < g_order.size()) return {1'b0, g_order[i]};
    return 2'b11;
  endfunction

  task automatic clear_mon();
    m_src.delete();
    m_pos.delete();
    g_order.delete();
  endtask

  task automatic set_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
  endtask

  task automatic present();
    req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
    req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
    if (q0_d.size() != 0) begin
      req0_valid = 1'b1; req0_data = q0_d[0]; req0_last = q0_l[0];
    end
    if (q1_d.size() != 0) begin
      req1_valid = 1'b1; req1_data = q1_d[0]; req1_last = q1_l[0];
    end
  endtask

  // Feed both word queues until drained and the DUT returns to idle
  task automatic run_traffic(input int max_cyc);
    int  c;
    logic h0, h1;
    c = 0;
    present();
    while ((q0_d.size() != 0 || q1_d.size() != 0 || busy) && c < max_cyc) begin
      @(negedge clk);
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (h0) begin void'(q0_d.pop_front()); void'(q0_l.pop_front()); end
      if (h1) begin void'(q1_d.pop_front()); void'(q1_l.pop_front()); end
      present();
      c++;
    end
    check("traffic_done", 32'(c < max_cyc), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Present one word and return at posedge+1 right after its acceptance edge
  task automatic handshake(input logic n, input logic [7:0] d, input logic l);
    int k;
    k = 0;
    if (n) begin req1_valid = 1'b1; req1_data = d; req1_last = l; end
    else   begin req0_valid = 1'b1; req0_data = d; req0_last = l; end
    do begin
      @(negedge clk);
      k++;
    end while (!(n ? req1_ready : req0_ready) && k < 50);
    check("handshake_ready", 32'(k < 50), 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic clear_cnt();
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    check("clr_cnt0", 32'(cnt0), 0);
    check("clr_cnt1", 32'(cnt1), 0);
  endtask

  task automatic one_word(input logic [7:0] d);
    clear_mon();
    q0_d.push_back(d);
    q0_l.push_back(1'b1);
    run_traffic(100);
  endtask

  initial begin
    rst_n = 1'b0; clr_cnt = 1'b0;
    set_cfg(8'h0D, 4'd4, 1'b1);
    present();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    check("rst_ready0", 32'(req0_ready), 0);
    check("rst_ready1", 32'(req1_ready), 0);
    check("rst_match_valid", 32'(match_valid), 0);
    check("rst_match_src", 32'(match_src), 0);
    check("rst_match_pos", 32'(match_pos), 0);
    check("rst_cnt0", 32'(cnt0), 0);
    check("rst_cnt1", 32'(cnt1), 0);
    check("rst_busy", 32'(busy), 0);
    @(posedge clk); #1;

    // Tie out of reset: req0, req1, req0; no match across the packet boundary
    clear_mon();
    q0_d.push_back(8'h06); q0_l.push_back(1'b1);
    q0_d.push_back(8'h06); q0_l.push_back(1'b1);
    q1_d.push_back(8'h80); q1_l.push_back(1'b1);
    run_traffic(200);
    check("t4_grants", 32'(g_order.size()), 3);
    check("t4_grant0", 32'(grant_at(0)), 0);
    check("t4_grant1", 32'(grant_at(1)), 1);
    check("t4_grant2", 32'(grant_at(2)), 0);
    check("t4_matches", 32'(m_pos.size()), 0);
    check("t4_cnt0", 32'(cnt0), 0);
    check("t4_cnt1", 32'(cnt1), 0);

    // Overlapping matches inside one word
    set_cfg(8'h0D, 4'd4, 1'b1);
    one_word(8'hDA);
    check("t1_matches", 32'(m_pos.size()), 2);
    check("t1_pos0", 32'(pos_at(0)), 3);
    check("t1_pos1", 32'(pos_at(1)), 6);
    check("t1_src0", 32'(src_at(0)), 0);
    check("t1_src1", 32'(src_at(1)), 0);
    check("t1_cnt0", 32'(cnt0), 2);

    // Non-overlapping keeps only the first
    clear_cnt();
    set_cfg(8'h0D, 4'd4, 1'b0);
    one_word(8'hDA);
    check("t2_matches", 32'(m_pos.size()), 1);
    check("t2_pos0", 32'(pos_at(0)), 3);
    check("t2_cnt0", 32'(cnt0), 1);

    // Match straddling the word boundary of a two-word packet
    clear_cnt();
    set_cfg(8'h0D, 4'd4, 1'b1);
    clear_mon();
    q0_d.push_back(8'h03); q0_l.push_back(1'b0);
    q0_d.push_back(8'h40); q0_l.push_back(1'b1);
    run_traffic(100);
    check("t3_matches", 32'(m_pos.size()), 1);
    check("t3_pos0", 32'(pos_at(0)), 9);
    check("t3_cnt0", 32'(cnt0), 1);

    // Length boundaries: 0 disables, 1 is a single bit, 15 clamps to 8
    set_cfg(8'hFF, 4'd0, 1'b1);
    one_word(8'hFF);
    check("len0_matches", 32'(m_pos.size()), 0);
    set_cfg(8'h01, 4'd1, 1'b1);
    one_word(8'h81);
    check("len1_matches", 32'(m_pos.size()), 2);
    check("len1_pos0", 32'(pos_at(0)), 0);
    check("len1_pos1", 32'(pos_at(1)), 7);
    clear_cnt();
    set_cfg(8'hA5, 4'd15, 1'b0);
    one_word(8'hA5);
    check("len15_matches", 32'(m_pos.size()), 1);
    check("len15_pos0", 32'(pos_at(0)), 7);

    // Reset in the middle of SHIFT abandons the packet
    check("t5_pre_cnt0", 32'(cnt0), 1);
    set_cfg(8'h0D, 4'd4, 1'b1);
    clear_mon();
    handshake(1'b0, 8'hDA, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    check("t5_pre_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("t5_ready0", 32'(req0_ready), 0);
    check("t5_ready1", 32'(req1_ready), 0);
    check("t5_match_valid", 32'(match_valid), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_cnt0", 32'(cnt0), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("t5_no_match", 32'(m_pos.size()), 0);
    check("t5_idle", 32'(busy), 0);
    clear_mon();
    q0_d.push_back(8'h00); q0_l.push_back(1'b1);
    q1_d.push_back(8'h00); q1_l.push_back(1'b1);
    run_traffic(100);
    check("t5_grant0", 32'(grant_at(0)), 0);
    check("t5_grant1", 32'(grant_at(1)), 1);

    // 260 matching packets on req1 saturate cnt1
    clear_mon();
    set_cfg(8'h0D, 4'd4, 1'b0);
    for (int i = 0; i < 260; i++) begin
      q1_d.push_back(8'hD0);
      q1_l.push_back(1'b1);
    end
    run_traffic(6000);
    check("t6_cnt1_sat", 32'(cnt1), 255);
    check("t6_cnt0", 32'(cnt0), 0);
    check("t6_pulses", 32'(m_pos.size()), 260);
    check("t6_last_src", 32'(src_at(259)), 1);
    check("t6_last_pos", 32'(pos_at(259)), 3);

    // clr_cnt on the same edge as a match wins over the increment
    handshake(1'b1, 8'hD0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    check("t6_clr_pulse", 32'(match_valid), 1);
    check("t6_clr_src", 32'(match_src), 1);
    check("t6_clr_cnt1", 32'(cnt1), 0);
    clr_cnt = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("t6_final_cnt1", 32'(cnt1), 0);
    check("t6_final_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
